// File: rtl/apb_master.sv
// APB3 requester: one command in, one SETUP/ACCESS transfer out, one response back.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT cycles without PREADY.
module apb_master #(
  parameter int AWIDTH  = 4,
  parameter int DWIDTH  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [DWIDTH-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [AWIDTH-1:0] PADDR,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [DWIDTH-1:0] PWDATA,
  input  logic [DWIDTH-1:0] PRDATA,
  input  logic              PREADY
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } state_e;

  state_e state_q, state_d;

  logic [AWIDTH-1:0] paddr_q, paddr_d;
  logic [DWIDTH-1:0] pwdata_q, pwdata_d;
  logic [DWIDTH-1:0] rdata_q, rdata_d;
  logic pwrite_q, pwrite_d;
  logic psel_q, psel_d;
  logic penable_q, penable_d;
  logic rvalid_q, rvalid_d;
  logic rerr_q, rerr_d;
  logic done, abort;

  assign done = (state_q == S_ACCESS) && PREADY;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // PREADY in the limit cycle wins, so abort needs PREADY low
  assign abort = (state_q == S_ACCESS) && !PREADY &&
                 (cnt_q == CW'(TIMEOUT));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_SETUP)
      cnt_d = '0;
    else if (state_q == S_ACCESS && !PREADY &&
             cnt_q != CW'(TIMEOUT))
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign abort = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (cmd_valid) state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: if (done || abort) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    rdata_d   = rdata_q;
    psel_d    = (state_d != S_IDLE);
    penable_d = (state_d == S_ACCESS);
    rvalid_d  = done || abort;
    rerr_d    = abort;
    if (state_q == S_IDLE && cmd_valid) begin
      paddr_d  = cmd_addr;
      pwrite_d = cmd_write;
      pwdata_d = cmd_wdata;
    end
    if (done)
      rdata_d = pwrite_q ? '0 : PRDATA;
    else if (abort)
      rdata_d = '0;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      rdata_q   <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rerr_q    <= 1'b0;
    end else begin
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      rdata_q   <= rdata_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      rvalid_q  <= rvalid_d;
      rerr_q    <= rerr_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign rsp_valid = rvalid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = rerr_q;

endmodule

// File: tb/tb_apb_master.sv
// Randomized bench for apb_master against a transaction-level model.
// Timeout expectations follow APB_MASTER_TIMEOUT_EN when it is defined.
module tb_apb_master;

  localparam int TMO = 16;

  logic       PCLK;
  logic       PRESETn;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [3:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic [3:0] PADDR;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;

  int n_checks;
  int n_errors;
  int exp_rdata;

  apb_master #(
    .AWIDTH (4),
    .DWIDTH (8),
    .TIMEOUT(TMO)
  ) dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .PADDR    (PADDR),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input int exp);
    n_checks++;
    if (obs !== 32'(exp)) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge PCLK);
      PREADY = 1'($urandom);
      PRDATA = 8'($urandom);
      chk("idle_psel", 32'(PSEL), 0);
      chk("idle_rsp_valid", 32'(rsp_valid), 0);
      chk("idle_rdata_hold", 32'(rsp_rdata), exp_rdata);
      chk("idle_cmd_ready", 32'(cmd_ready), 1);
    end
  endtask

  // One transfer; waits = PREADY-low cycles before ready.
  // Ends on the response cycle, where a new command may be driven.
  task automatic xfer(input int wr, input int a, input int wd,
                      input int waits, input int rd, input int hold);
    int n_acc;
    int err;
    n_acc = waits + 1;
    err   = 0;
`ifdef APB_MASTER_TIMEOUT_EN
    if (waits > TMO) begin
      n_acc = TMO + 1;
      err   = 1;
    end
`endif
    cmd_valid = 1'b1;
    cmd_write = 1'(wr);
    cmd_addr  = 4'(a);
    cmd_wdata = 8'(wd);
    #1 chk("accept_ready", 32'(cmd_ready), 1);
    @(negedge PCLK);
    cmd_valid = 1'(hold);
    cmd_write = 1'($urandom);
    cmd_addr  = 4'($urandom);
    cmd_wdata = 8'($urandom);
    PREADY    = 1'($urandom);
    PRDATA    = 8'($urandom);
    chk("setup_psel", 32'(PSEL), 1);
    chk("setup_penable", 32'(PENABLE), 0);
    chk("setup_paddr", 32'(PADDR), a);
    chk("setup_pwrite", 32'(PWRITE), wr);
    chk("setup_pwdata", 32'(PWDATA), wd);
    chk("setup_cmd_ready", 32'(cmd_ready), 0);
    chk("setup_rsp_valid", 32'(rsp_valid), 0);
    for (int i = 0; i < n_acc; i++) begin
      @(negedge PCLK);
      PREADY = (i == waits);
      PRDATA = (i == waits) ? 8'(rd) : 8'($urandom);
      chk("acc_psel", 32'(PSEL), 1);
      chk("acc_penable", 32'(PENABLE), 1);
      chk("acc_paddr", 32'(PADDR), a);
      chk("acc_pwrite", 32'(PWRITE), wr);
      chk("acc_pwdata", 32'(PWDATA), wd);
      chk("acc_cmd_ready", 32'(cmd_ready), 0);
      chk("acc_rsp_valid", 32'(rsp_valid), 0);
    end
    @(negedge PCLK);
    PREADY    = 1'($urandom);
    PRDATA    = 8'($urandom);
    exp_rdata = (wr != 0 || err != 0) ? 0 : rd;
    chk("rsp_valid", 32'(rsp_valid), 1);
    chk("rsp_err", 32'(rsp_err), err);
    chk("rsp_rdata", 32'(rsp_rdata), exp_rdata);
    chk("rsp_psel", 32'(PSEL), 0);
    chk("rsp_penable", 32'(PENABLE), 0);
    chk("rsp_cmd_ready", 32'(cmd_ready), 1);
    chk("rsp_paddr_kept", 32'(PADDR), a);
  endtask

  task automatic chk_reset_vals;
    chk("rst_psel", 32'(PSEL), 0);
    chk("rst_penable", 32'(PENABLE), 0);
    chk("rst_pwrite", 32'(PWRITE), 0);
    chk("rst_paddr", 32'(PADDR), 0);
    chk("rst_pwdata", 32'(PWDATA), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
  endtask

  initial begin
    int hold;
    n_checks  = 0;
    n_errors  = 0;
    exp_rdata = 0;
    PRESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    PRDATA    = '0;
    PREADY    = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    chk_reset_vals();
    PRESETn = 1'b1;
    idle(2);

    xfer(1, 2, 8'hA5, 0, 0, 0);
    idle(2);
    xfer(0, 5, 8'h11, 3, 8'h3C, 0);
    idle(1);

    xfer(1, 9, 8'h5A, 1, 0, 1);
    xfer(0, 3, 8'h00, 0, 8'hC3, 0);
    idle(1);

    // reset while ACCESS is waiting
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 4'h7;
    cmd_wdata = 8'h99;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    PREADY    = 1'b0;
    @(negedge PCLK);
    chk("pre_rst_penable", 32'(PENABLE), 1);
    #2 PRESETn = 1'b0;
    #1 chk("async_psel", 32'(PSEL), 0);
    chk("async_penable", 32'(PENABLE), 0);
    @(negedge PCLK);
    @(negedge PCLK);
    chk_reset_vals();
    PRESETn   = 1'b1;
    exp_rdata = 0;
    idle(3);
    xfer(0, 4'hE, 0, 1, 8'h42, 0);
    idle(1);

    for (int k = 0; k < 40; k++) begin
      hold = (k == 39) ? 0 : int'($urandom_range(0, 1));
      xfer(int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 255)), hold);
      if (hold == 0) idle(int'($urandom_range(0, 2)));
    end
    idle(1);

`ifdef APB_MASTER_TIMEOUT_EN
    xfer(0, 6, 0, TMO, 8'h77, 0);
    idle(1);
    xfer(0, 8, 0, 200, 8'h55, 0);
    idle(2);
`else
    xfer(0, 6, 0, 100, 8'h77, 0);
    idle(2);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
